// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, control states and datapath mux-select encodings for the multi-cycle core.
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_LUI = 4'd5,
    S_ADDR     = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_WB_ALU   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd15
  } state_t;
  localparam logic [1:0] ALU_A_PC    = 2'd0;
  localparam logic [1:0] ALU_A_OLDPC = 2'd1;
  localparam logic [1:0] ALU_A_RS1   = 2'd2;
  localparam logic [1:0] ALU_A_ZERO  = 2'd3;
  localparam logic [1:0] ALU_B_RS2   = 2'd0;
  localparam logic [1:0] ALU_B_IMM   = 2'd1;
  localparam logic [1:0] ALU_B_FOUR  = 2'd2;
  localparam logic [1:0] ALU_OP_ADD  = 2'd0;
  localparam logic [1:0] ALU_OP_SUB  = 2'd1;
  localparam logic [1:0] ALU_OP_FN   = 2'd2;
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;
  function automatic logic is_mem(state_t s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction
endpackage

// File: rtl/riscv_mem_watchdog.sv
// riscv_mem_watchdog: wait-cycle counter for memory states; ports clk, rst (async active-low), clr, inc, expired.
module riscv_mem_watchdog #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  assign expired = cnt == CNT_W'(MEM_TIMEOUT);
endmodule

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle control FSM; inputs opcode/branch_taken/mem_ready, outputs memory port, PC/IR/reg enables, mux selects, trap, state.
module riscv_mc_control
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       trap,
  output logic [3:0] state
);
  state_t cur, nxt;
  logic in_mem, expired;
  // Counter is held clear outside memory states and on the completing cycle,
  // so it always reads 0 on entry, including the direct MEM_WR -> FETCH hop.
  assign in_mem = is_mem(cur);
  riscv_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(!in_mem || mem_ready),
    .inc(in_mem && !mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) cur <= S_INIT;
    else cur <= nxt;
  always_comb begin
    nxt = S_TRAP;
    case (cur)
      S_INIT:     nxt = S_FETCH;
      S_FETCH:    nxt = mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_R:              nxt = S_EXEC_R;
          OP_I:              nxt = S_EXEC_I;
          OP_LUI:            nxt = S_EXEC_LUI;
          OP_LOAD, OP_STORE: nxt = S_ADDR;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_TRAP;
        endcase
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: nxt = S_WB_ALU;
      S_ADDR:     nxt = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = mem_ready ? S_WB_MEM : expired ? S_TRAP : S_MEM_RD;
      S_MEM_WR:   nxt = mem_ready ? S_FETCH : expired ? S_TRAP : S_MEM_WR;
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JAL: nxt = S_FETCH;
      default:    nxt = S_TRAP;
    endcase
  end
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = ALU_A_PC;
    alu_src_b  = ALU_B_RS2;
    alu_op     = ALU_OP_ADD;
    result_src = RES_ALUOUT;
    trap       = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        alu_src_b = ALU_B_FOUR;
      end
      S_DECODE: begin
        alu_src_a = ALU_A_OLDPC;
        alu_src_b = ALU_B_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = ALU_A_RS1;
        alu_op    = ALU_OP_FN;
      end
      S_EXEC_I: begin
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_IMM;
        alu_op    = ALU_OP_FN;
      end
      S_EXEC_LUI: begin
        alu_src_a = ALU_A_ZERO;
        alu_src_b = ALU_B_IMM;
      end
      S_ADDR: begin
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        result_src = RES_MEM;
      end
      S_WB_ALU:   reg_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = ALU_A_RS1;
        alu_op    = ALU_OP_SUB;
        pc_src    = 1'b1;
        pc_we     = branch_taken;
      end
      S_JAL: begin
        alu_src_a  = ALU_A_OLDPC;
        alu_src_b  = ALU_B_FOUR;
        result_src = RES_ALU;
        reg_we     = 1'b1;
        pc_src     = 1'b1;
        pc_we      = 1'b1;
      end
      S_TRAP:     trap = 1'b1;
      default: ;
    endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: randomized instruction-level scoreboard bench for riscv_mc_control.
module tb_riscv_mc_control;
  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] opcode = '0;
  logic branch_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, reg_we, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;
  logic [19:0] got;
  logic [19:0] q[$];
  logic rand_idle = 1'b0;
  int errors = 0, checks = 0;
  riscv_mc_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .trap(trap), .state(state)
  );
  always #5 clk = ~clk;
  assign got = {state, mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, reg_we,
                alu_src_a, alu_src_b, alu_op, result_src, trap};
  // Expected control word for one cycle, straight from the per-state output table.
  function automatic logic [19:0] exp_vec(int st, logic rdy, logic tk);
    logic mq = 0, mw = 0, ad = 0, iw = 0, pw = 0, ps = 0, rw = 0, tr = 0;
    logic [1:0] a = 0, b = 0, op = 0, rs = 0;
    case (st)
      1:  begin mq = 1; iw = rdy; pw = rdy; b = 2; end
      2:  begin a = 1; b = 1; end
      3:  begin a = 2; op = 2; end
      4:  begin a = 2; b = 1; op = 2; end
      5:  begin a = 3; b = 1; end
      6:  begin a = 2; b = 1; end
      7:  begin mq = 1; ad = 1; end
      8:  begin mq = 1; mw = 1; ad = 1; end
      9:  begin rw = 1; rs = 1; end
      10: rw = 1;
      11: begin a = 2; op = 1; ps = 1; pw = tk; end
      12: begin a = 1; b = 2; rs = 2; rw = 1; ps = 1; pw = 1; end
      15: tr = 1;
      default: ;
    endcase
    return {st[3:0], mq, mw, ad, iw, pw, ps, rw, a, b, op, rs, tr};
  endfunction
  task automatic chk(string name, logic [19:0] g, logic [19:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, g, w);
    end
  endtask
  // One clock cycle the model expects the DUT to spend in state st.
  task automatic cyc(int st, logic rdy, logic [6:0] op, logic tk);
    @(posedge clk);
    #1;
    opcode = op;
    mem_ready = (st == 1 || st == 7 || st == 8) ? rdy : (rand_idle ? 1'($urandom) : 1'b1);
    branch_taken = (st == 11) ? tk : 1'($urandom);
    q.push_back(exp_vec(st, mem_ready, branch_taken));
  endtask
  task automatic mem_phase(int st, int waits, logic [6:0] op);
    repeat (waits) cyc(st, 1'b0, op, 1'b0);
    cyc(st, 1'b1, op, 1'b0);
  endtask
  // Instruction-level model: kind 0=R 1=I 2=LUI 3=load 4=store 5=branch 6=JAL.
  task automatic run(int kind, int wf, int wm, logic tk);
    logic [6:0] op;
    case (kind)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0110111;
      3: op = 7'b0000011;
      4: op = 7'b0100011;
      5: op = 7'b1100011;
      default: op = 7'b1101111;
    endcase
    mem_phase(1, wf, 7'($urandom));
    cyc(2, 1'b0, op, 1'b0);
    case (kind)
      0: begin cyc(3, 0, op, 0); cyc(10, 0, op, 0); end
      1: begin cyc(4, 0, op, 0); cyc(10, 0, op, 0); end
      2: begin cyc(5, 0, op, 0); cyc(10, 0, op, 0); end
      3: begin cyc(6, 0, op, 0); mem_phase(7, wm, op); cyc(9, 0, op, 0); end
      4: begin cyc(6, 0, op, 0); mem_phase(8, wm, op); end
      5: cyc(11, 0, op, tk);
      default: cyc(12, 0, op, 0);
    endcase
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    opcode = 7'($urandom);
    mem_ready = 1'b1;
    #1 chk("reset_async", got, 20'h0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", got, 20'h0);
    end
    #1 rst = 1'b1;
  endtask
  always @(negedge clk) begin : monitor
    logic [19:0] e;
    if (rst && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got=%h want=%h", $time, got, e);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit");
  end
  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_init", got, 20'h0);
    end
    #1 rst = 1'b1;
    run(0, 0, 0, 1'b0);
    run(3, 0, 3, 1'b0);
    run(5, 0, 0, 1'b1);
    run(5, 0, 0, 1'b0);
    run(6, 1, 0, 1'b0);
    rand_idle = 1'b1;
    // Illegal opcode traps after DECODE and stays trapped.
    cyc(1, 1'b1, 7'($urandom), 1'b0);
    cyc(2, 1'b0, 7'b0000000, 1'b0);
    repeat (5) cyc(15, 1'b0, 7'($urandom), 1'b0);
    do_reset();
    // FETCH stalled: 16 cycles in FETCH, then TRAP.
    repeat (16) cyc(1, 1'b0, 7'($urandom), 1'b0);
    repeat (5) cyc(15, 1'b0, 7'($urandom), 1'b0);
    do_reset();
    // Ready arriving at count==timeout completes normally.
    run(1, 15, 15, 1'b0);
    run(4, 15, 15, 1'b0);
    // MEM_RD stalled until trap.
    cyc(1, 1'b1, 7'($urandom), 1'b0);
    cyc(2, 1'b0, 7'b0000011, 1'b0);
    cyc(6, 1'b0, 7'b0000011, 1'b0);
    repeat (16) cyc(7, 1'b0, 7'b0000011, 1'b0);
    repeat (3) cyc(15, 1'b0, 7'b0000011, 1'b0);
    do_reset();
    // Reset in the middle of a stalled store.
    cyc(1, 1'b1, 7'($urandom), 1'b0);
    cyc(2, 1'b0, 7'b0100011, 1'b0);
    cyc(6, 1'b0, 7'b0100011, 1'b0);
    cyc(8, 1'b0, 7'b0100011, 1'b0);
    cyc(8, 1'b0, 7'b0100011, 1'b0);
    do_reset();
    run(0, 0, 0, 1'b0);
    for (int i = 0; i < 80; i++)
      run($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multi-cycle control FSM for the RISC-V core. Each instruction is sequenced through fetch, decode, execute, memory and writeback.
- Drives the PC/IR write enables, the datapath mux selects, the ALU op class and the single shared memory port.
- The memory port uses a req/ready handshake. A memory watchdog traps the core on a stalled access.
- Sits beside the datapath inside the core top, between the PC register, instruction register, register file and memory.

Parameters:
- MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before trapping (1..255).
- CNT_W, 8, width of the watchdog counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the IR.
- branch_taken  in  1  comparator result for the current branch.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store strobe; valid only with mem_req.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC register write.
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut.
- reg_we  out  1  register file write.
- alu_src_a  out  2  ALU A select: 0=PC, 1=oldPC, 2=rs1, 3=zero.
- alu_src_b  out  2  ALU B select: 0=rs2, 1=imm, 2=const 4.
- alu_op  out  2  ALU op class: 0=add, 1=sub, 2=funct-decoded.
- result_src  out  2  writeback source: 0=ALUOut, 1=mem rdata, 2=ALU result.
- trap  out  1  sticky fault flag.
- state  out  4  current state, for debug and the bench.

Behaviour:
- State register updates on the clk rising edge; async clear when rst=0.
- All outputs are decoded combinationally from state, plus mem_ready/branch_taken where noted.
- While rst=0 the state is INIT and every output is 0 (state=0).
- Unlisted outputs are 0 in every state.
- States and encodings:
  - INIT=0: all outputs 0. Next: FETCH.
  - FETCH=1: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=0, pc_src=0. ir_we=pc_we=mem_ready. Next: DECODE on mem_ready, else stay.
  - DECODE=2: alu_src_a=1, alu_src_b=1, alu_op=0 (branch/JAL target latched into ALUOut). Dispatch on opcode:
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I.
    - 0110111 (LUI) -> EXEC_LUI.
    - 0000011 and 0100011 -> ADDR.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - any other opcode -> TRAP.
  - EXEC_R=3: alu_src_a=2, alu_src_b=0, alu_op=2. Next: WB_ALU.
  - EXEC_I=4: alu_src_a=2, alu_src_b=1, alu_op=2. Next: WB_ALU.
  - EXEC_LUI=5: alu_src_a=3, alu_src_b=1, alu_op=0. Next: WB_ALU.
  - ADDR=6: alu_src_a=2, alu_src_b=1, alu_op=0. Next: MEM_RD for a load, MEM_WR for a store (opcode bit 5).
  - MEM_RD=7: mem_req=1, adr_src=1. Next: WB_MEM on mem_ready.
  - MEM_WR=8: mem_req=1, mem_we=1, adr_src=1. Next: FETCH on mem_ready.
  - WB_MEM=9: reg_we=1, result_src=1. Next: FETCH.
  - WB_ALU=10: reg_we=1, result_src=0. Next: FETCH.
  - BRANCH=11: alu_src_a=2, alu_src_b=0, alu_op=1, pc_src=1, pc_we=branch_taken. Next: FETCH.
  - JAL=12: alu_src_a=1, alu_src_b=2, alu_op=0, result_src=2, reg_we=1, pc_src=1, pc_we=1. Next: FETCH.
  - TRAP=15: trap=1, all enables 0. Stays until reset.
- Latency with zero memory wait states:

  | Instruction | Cycles |
  |---|---|
  | R / I / LUI | 4 |
  | load | 5 |
  | store | 4 |
  | branch | 3 |
  | JAL | 3 |

  Each wait cycle adds 1 cycle.
- Handshake:
  - mem_req is held high and the address select stable until the mem_ready cycle.
  - The transfer happens in the cycle where mem_req & mem_ready.
  - mem_ready outside a memory state is ignored.
- Watchdog:
  - The counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each wait cycle.
  - When count==MEM_TIMEOUT with mem_ready=0, next state is TRAP; no ir_we/pc_we is issued.
  - mem_ready in the same cycle as count==MEM_TIMEOUT completes the access normally; ready wins.
- Reset mid-operation:
  - Immediate INIT, so mem_req drops asynchronously.
  - Resets the counter and clears trap.
- Unused state codes 13, 14 -> TRAP.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL;
  - state encodings;
  - mux-select encodings for ALU_A, ALU_B, ALU_OP, RESULT.
- One sub-module, riscv_mem_watchdog: counter with clear, inc and expired output, parameterised by MEM_TIMEOUT and CNT_W.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: state=0 and all outputs 0 during reset; state=1 and mem_req=1 on the cycle after release.
- R-type (opcode 0110011) with mem_ready always 1. Required: states 1,2,3,10,1; one ir_we/pc_we pulse in FETCH; reg_we only in state 10.
- Load with 3 wait cycles in MEM_RD. Required: mem_req=1 and adr_src=1 held for 4 cycles; WB_MEM is entered exactly once; load total is 8 cycles.
- Branch, twice. With branch_taken=1: pc_we=1 and pc_src=1 in state 11. With branch_taken=0: pc_we=0 and the next state is still FETCH.
- Illegal opcode 0000000, and separately mem_ready stuck at 0 with MEM_TIMEOUT=15. Required: trap=1 (TRAP after DECODE, or 16 cycles after FETCH entry); stays trapped; cleared only by rst=0.
- Assert rst=0 mid-MEM_WR. Required: mem_req and mem_we fall asynchronously; state=0; restart at FETCH with no reg_we.
